// File: rtl/fir_tap_scheduler.sv
// Purpose : time-multiplexed FIR sequencer; one multiply-accumulate walks all taps, one per clock.
// Latency : sample accepted at edge T0, result registered at edge T0+LENGTH; next accept at T0+LENGTH+2.
// Backpr. : in_ready only in IDLE (upstream holds the sample); result held in DONE until out_ready.
//
// Ports:
//   clock_s, reset              - system clock, asynchronous active-high reset
//   in / in_valid / in_ready    - unsigned sample input, valid/ready handshake
//   out / out_valid / out_ready - registered filtered result, valid/ready handshake
//   cfg_we / cfg_addr / cfg_data - coefficient write port, honoured only in IDLE
//   busy                        - high while a transaction is in MAC or DONE
module fir_tap_scheduler #(
  parameter int N      = 12,
  parameter int LENGTH = 19,
  parameter int IDX_W  = 5
) (
  input  logic             clock_s,
  input  logic             reset,
  input  logic [N:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [N-1:0]     cfg_data,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(LENGTH);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       hist_q [LENGTH];
  logic [N:0]       hist_d [LENGTH];
  logic [N-1:0]     coef_q [LENGTH];
  logic [N-1:0]     coef_d [LENGTH];
  logic [IDX_W-1:0] wp_q, wp_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic [N:0]       acc_q, acc_d;
  logic [N:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;

  // Tap datapath
  logic [IDX_W-1:0] rd_idx;
  logic [N-1:0]     tap_coef;
  logic [N:0]       tap_sample;
  logic [N:0]       prod_lo;
  logic [N:0]       acc_next;
  logic [IDX_W-1:0] wp_inc;
  logic             cfg_hit;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

  // History slot for the current tap: (base - tap) mod LENGTH. Both operands are
  // already in 0..LENGTH-1, so a single conditional wrap is enough.
  always_comb begin
    rd_idx = '0;
    if (tap_q <= base_q) begin
      rd_idx = base_q - tap_q;
    end else begin
      rd_idx = base_q + (LEN_IDX - tap_q);
    end
  end

  // Explicit read muxes keep every select inside the populated range.
  always_comb begin
    tap_coef   = '0;
    tap_sample = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (tap_q == IDX_W'(i)) begin
        tap_coef = coef_q[i];
      end
      if (rd_idx == IDX_W'(i)) begin
        tap_sample = hist_q[i];
      end
    end
  end

  // The accumulator wraps modulo 2^(N+1), and the low N+1 bits of a product depend
  // only on the low N+1 bits of its operands, so this narrow multiply yields exactly
  // the low bits of the full-width product; the discarded high bits could never
  // reach the result.
  assign prod_lo  = {1'b0, tap_coef} * tap_sample;
  assign acc_next = acc_q + prod_lo;

  assign wp_inc  = (wp_q == LAST_TAP) ? '0 : wp_q + IDX_W'(1);
  assign cfg_hit = cfg_we && (cfg_addr < LEN_IDX);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    wp_d        = wp_q;
    base_d      = base_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        // A coefficient written in the same cycle a sample is accepted lands in
        // the bank at that edge, so the new sample's MAC pass already sees it.
        if (cfg_hit) begin
          for (int i = 0; i < LENGTH; i++) begin
            if (cfg_addr == IDX_W'(i)) begin
              coef_d[i] = cfg_data;
            end
          end
        end
        if (in_valid) begin
          for (int i = 0; i < LENGTH; i++) begin
            if (wp_q == IDX_W'(i)) begin
              hist_d[i] = in;
            end
          end
          base_d  = wp_q;
          wp_d    = wp_inc;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end

      S_MAC: begin
        acc_d = acc_next;
        if (tap_q == LAST_TAP) begin
          out_d       = acc_next;
          out_valid_d = 1'b1;
          tap_d       = '0;
          state_d     = S_DONE;
        end else begin
          tap_d = tap_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_s or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      base_q      <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      base_q      <= base_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Purpose : directed bench for fir_tap_scheduler with a queue scoreboard and a separate output monitor.
// Latency : checks that every result rises LENGTH cycles after its sample was accepted.
// Backpr. : exercises held out_ready=0 with a pending sample on the input.
module tb_fir_tap_scheduler;

  localparam int N      = 12;
  localparam int LENGTH = 19;
  localparam int IDX_W  = 5;

  logic             clock_s   = 1'b0;
  logic             reset     = 1'b1;
  logic [N:0]       in        = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [N:0]       out;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             cfg_we    = 1'b0;
  logic [IDX_W-1:0] cfg_addr  = '0;
  logic [N-1:0]     cfg_data  = '0;
  logic             busy;

  int         checks     = 0;
  int         failures   = 0;
  int         cyc        = 0;
  int         accept_cyc = 0;
  int         accept_cnt = 0;
  logic       prev_ov    = 1'b0;
  logic [N:0] sb_q[$];

  fir_tap_scheduler #(.N(N), .LENGTH(LENGTH), .IDX_W(IDX_W)) dut (
    .clock_s   (clock_s),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy)
  );

  always #5 clock_s = ~clock_s;
  always @(posedge clock_s) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pairs each output handshake with the
  // oldest expected value and checks the acceptance-to-valid latency.
  always @(negedge clock_s) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        accept_cyc = cyc + 1;
        accept_cnt++;
      end
      if (out_valid && !prev_ov) begin
        check("latency", cyc - accept_cyc, LENGTH);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: actual=%0d required=no output", out);
        end else begin
          check("out", int'(out), int'(sb_q.pop_front()));
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick;
    @(posedge clock_s);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic write_coef(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_data = N'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int v, input int e);
    wait_ready();
    in       = (N+1)'(v);
    in_valid = 1'b1;
    sb_q.push_back((N+1)'(e));
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_acc;

    repeat (2) @(posedge clock_s);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    tick();

    // Coefficient bank is zero after reset.
    send(3, 0);

    // Identity with the coefficient write in the same cycle as the sample.
    wait_ready();
    cfg_we   = 1'b1;
    cfg_addr = '0;
    cfg_data = N'(1);
    in       = (N+1)'(5);
    in_valid = 1'b1;
    sb_q.push_back((N+1)'(5));
    tick();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    wait_ready();

    // Reset while idle clears the held result (and the history and bank).
    reset = 1'b1;
    #1;
    check("idle_rst_out", out, 0);
    tick();
    reset = 1'b0;
    tick();

    // Impulse response: coef[i] = i+1; outputs 1..19 then 0, wrapping wp.
    for (int i = 0; i < LENGTH; i++) write_coef(i, i + 1);
    send(1, 1);
    for (int k = 1; k <= LENGTH; k++) send(0, (k < LENGTH) ? k + 1 : 0);
    wait_ready();

    // Backpressure and config gating. History is all zero here.
    out_ready = 1'b0;
    send(1, 1);
    tick();
    tick();
    cfg_we   = 1'b1;             // write during MAC: must be dropped
    cfg_addr = IDX_W'(18);
    cfg_data = N'(100);
    tick();
    cfg_we   = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    in       = '0;
    in_valid = 1'b1;
    sb_q.push_back((N+1)'(2));   // newest 0, the 1 one back -> coef[1] = 2
    n_acc    = accept_cnt;
    cfg_we   = 1'b1;             // write during DONE: must be dropped
    cfg_addr = IDX_W'(10);
    cfg_data = N'(55);
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, 1);
      check("bp_out_valid", out_valid, 1);
      check("bp_no_accept", accept_cnt, n_acc);
      tick();
      cfg_we = 1'b0;
    end
    out_ready = 1'b1;
    tick();                      // handshake edge
    check("hs_in_ready", in_ready, 1);
    check("hs_no_accept", accept_cnt, n_acc);
    tick();                      // acceptance one cycle later
    check("hs_accept", accept_cnt, n_acc + 1);
    check("hs_busy", busy, 1);
    in_valid = 1'b0;

    // Out-of-range addresses are ignored.
    wait_ready();
    write_coef(25, 77);
    write_coef(31, 77);
    // The single 1 walks back through the taps: coef[2..18] = 3..19.
    for (int k = 3; k <= LENGTH; k++) send(0, k);
    wait_ready();

    // Overflow wrap: 4095*8191 mod 8192 = 4097 per populated tap.
    for (int i = 0; i < LENGTH; i++) write_coef(i, 4095);
    for (int k = 1; k <= 20; k++) send(8191, (((k > 19) ? 19 : k) * 4097) % 8192);
    wait_ready();

    // Reset in the tenth MAC cycle aborts the transaction.
    send(100, 0);
    repeat (9) tick();
    check("mid_busy", busy, 1);
    reset = 1'b1;
    void'(sb_q.pop_back());
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();

    // With every coefficient 1 the result is the sum of the history: only the
    // new sample survives if the history was cleared.
    for (int i = 0; i < LENGTH; i++) write_coef(i, 1);
    send(7, 7);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_scheduler.md
# fir_tap_scheduler

Time-multiplexed sequencer for the 12-bit binary FIR datapath: it accepts one input sample per transaction and walks a single multiply-accumulate unit over all taps, one tap per clock. It owns the sample history ring buffer and a run-time programmable coefficient bank, and it returns one filtered result per accepted sample. It sits between the sampling front end and downstream consumers. It replaces the fully parallel tap sum wherever area matters more than throughput.

## Interface
- `N`, 12: coefficient width; sample and result width is N+1.
- `LENGTH`, 19: number of taps (filter order + 1).
- `IDX_W`, 5: tap index / pointer width, with 2^IDX_W ≥ LENGTH.
- `clock_s` in 1: sampling/system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in` in N+1: input sample, unsigned binary.
- `in_valid` in 1: `in` is valid.
- `in_ready` out 1: block can accept a sample this cycle.
- `out` out N+1: filtered result, registered.
- `out_valid` out 1: `out` holds a new result.
- `out_ready` in 1: consumer takes `out` this cycle.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_addr` in IDX_W: coefficient index.
- `cfg_data` in N: coefficient value.
- `busy` out 1: high in MAC or DONE.

## Operation
- Storage: `hist[0..LENGTH-1]` (N+1 bits), `coef[0..LENGTH-1]` (N bits), write pointer `wp`, tap counter `tap`, accumulator `acc` (N+1 bits).
- Tap i multiplies `coef[i]` by the sample accepted i transactions ago. Tap 0 uses the newest sample.
- States:
  - IDLE: `in_ready`=1. When `in_valid` is high, store `in` into `hist[wp]`, latch `base`=`wp`, advance `wp` (LENGTH-1 wraps to 0), clear `acc` and `tap`, and go to MAC.
  - MAC: each cycle, `acc` ← `acc` + `coef[tap]`·`hist[(base−tap) mod LENGTH]`, then `tap`++. After the update with `tap`=LENGTH-1, load `out` with the final sum, set `out_valid`=1, and go to DONE.
  - DONE: hold `out` and `out_valid`. When `out_ready`=1, clear `out_valid` and go to IDLE.
- Arithmetic: all values are unsigned. The product is formed at full width. Accumulation is modulo 2^(N+1): the result is truncated, not saturated.
- Coefficient writes:
  - Accepted only in IDLE with `cfg_addr` < LENGTH.
  - A write with `cfg_addr` ≥ LENGTH is ignored.
  - A write in MAC or DONE is ignored, not queued.
- Simultaneous `cfg_we` and `in_valid` in IDLE: both take effect. The new coefficient is used by the sample accepted in that same cycle.
- Reset values:
  - `out`=0, `out_valid`=0, state IDLE, so `in_ready`=1 and `busy`=0.
  - `wp`=0, `tap`=0, `acc`=0; all `hist` and all `coef` entries = 0.
- Reset asserted mid-MAC or mid-DONE aborts the transaction. No result is produced and the history is cleared.

## Timing
- `in_ready` and `busy` are combinational decodes of the state. `out` and `out_valid` are registered.
- Sample accepted at edge T0. MAC occupies edges T1..T_LENGTH. `out_valid` is high after edge T_LENGTH, which is 19 cycles for the default parameters.
- If `out_ready` is held high, the transaction completes at T_LENGTH+1 and the next sample can be accepted at T_LENGTH+2. Sustained throughput is one sample per LENGTH+2 cycles.
- `in_valid` while not in IDLE is not consumed. The upstream block must hold the sample until `in_ready`=1.
- `out_ready` outside DONE has no effect.

## Test plan
- Identity: write `coef[0]`=1 and all others 0, then send 5. Required: `out`=5, with `out_valid` rising 19 cycles after acceptance.
- Impulse response:
  - Stimulus: write `coef[i]`=i+1, then send 1 followed by 19 zeros, with `out_ready` tied to 1.
  - Required: outputs 1, 2, …, 19, then 0. This also checks `wp` wrap-around.
- Overflow wrap: set all coefficients to 4095 and send 8191 twenty times. Required: the 19th and 20th results are 4115, i.e. (19·4095·8191) mod 8192.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`, with `in_valid` held high throughout.
  - Required: `out` is stable, `in_ready`=0, and no sample is accepted until one cycle after the handshake.
- Config gating:
  - Stimulus: issue `cfg_we` during MAC, and separately with `cfg_addr`=25.
  - Required: the coefficient bank is unchanged and results match those from the prior coefficients.
- Reset mid-MAC: assert `reset` at the tenth MAC cycle. Required: `out_valid`=0 and `out`=0 immediately, and a subsequent identity test yields the new sample only, since the history is cleared.
